// File: rtl/inst_queue.sv
// Instruction queue between ifetch and decode.
// Buffers up to DEPTH fetched {inst, pc} pairs and hands them to decode in
// order with a valid/ready handshake. stall_o backpressures ifetch when full,
// and flush_i empties the queue in one cycle on a branch redirect.
// Optional feature (define IQ_BYPASS_EN): when the queue is empty, an
// incoming instruction is forwarded combinationally to decode.
module inst_queue #(
   parameter int unsigned WORD  = 32,
   parameter int unsigned ADDR  = 16,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNTW  = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            v_i,
   input  logic [WORD-1:0] inst_i,
   input  logic [ADDR-1:0] pc_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            v_o,
   output logic [WORD-1:0] inst_o,
   output logic [ADDR-1:0] pc_o,
   input  logic            ready_i,
   output logic [CNTW-1:0] count_o
);

   localparam int unsigned IDXW = CNTW - 1;

   logic [WORD+ADDR-1:0] mem [DEPTH];
   logic [CNTW-1:0]      rp, wp;
   logic                 empty, full;
   logic                 push, pop;
   logic [WORD-1:0]      head_inst;
   logic [ADDR-1:0]      head_pc;

   // Occupancy flags from the wrap-flagged pointers
   always_comb begin
      empty = (rp == wp);
      full  = (rp[IDXW-1:0] == wp[IDXW-1:0]) && (rp[CNTW-1] != wp[CNTW-1]);
   end

   // Head entry read and handshake decode
   always_comb begin
      head_inst = mem[rp[IDXW-1:0]][WORD+ADDR-1:ADDR];
      head_pc   = mem[rp[IDXW-1:0]][ADDR-1:0];
      stall_o   = full;
      count_o   = wp - rp;
      // Only a stored entry can be popped; a bypassed beat never touches rp.
      pop       = !empty && ready_i && !flush_i;
`ifdef IQ_BYPASS_EN
      // A beat consumed straight from the input is not written.
      push      = v_i && !full && !flush_i && !(empty && ready_i);
      v_o       = !empty || (v_i && !flush_i);
      inst_o    = empty ? inst_i : head_inst;
      pc_o      = empty ? pc_i : head_pc;
`else
      push      = v_i && !full && !flush_i;
      v_o       = !empty;
      inst_o    = head_inst;
      pc_o      = head_pc;
`endif
   end

   // Entry storage; not reset, contents are qualified by the pointers
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wp[IDXW-1:0]] <= {inst_i, pc_i};
      end
   end

   // Pointer update; flush wins over push and pop
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rp <= '0;
         wp <= '0;
      end else if (flush_i) begin
         rp <= '0;
         wp <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop)  rp <= rp + 1'b1;
      end
   end

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue (DEPTH=4).
module tb_inst_queue;

   logic        clk;
   logic        rst;
   logic        v_i;
   logic [31:0] inst_i;
   logic [15:0] pc_i;
   logic        flush_i;
   logic        stall_o;
   logic        v_o;
   logic [31:0] inst_o;
   logic [15:0] pc_o;
   logic        ready_i;
   logic [2:0]  count_o;

   int total;
   int bad;

   inst_queue #(
      .WORD  (32),
      .ADDR  (16),
      .DEPTH (4),
      .CNTW  (3)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .v_i     (v_i),
      .inst_i  (inst_i),
      .pc_i    (pc_i),
      .flush_i (flush_i),
      .stall_o (stall_o),
      .v_o     (v_o),
      .inst_o  (inst_o),
      .pc_o    (pc_o),
      .ready_i (ready_i),
      .count_o (count_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Stimulus only: push n beats with decode blocked, pc from base.
   task automatic push_n(input int n, input logic [15:0] base);
      for (int i = 0; i < n; i++) begin
         v_i     = 1'b1;
         ready_i = 1'b0;
         pc_i    = base + 16'(i);
         inst_i  = 32'hA000_0000 + 32'(base) + 32'(i);
         @(negedge clk);
      end
      v_i = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b0; v_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0;
      inst_i = '0; pc_i = '0;
      @(negedge clk);
      @(negedge clk);
      total++;
      if (v_o !== 1'b0) begin bad++; $display("FAIL reset_v: got %b want 0", v_o); end
      total++;
      if (stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall_o); end
      total++;
      if (count_o !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count_o); end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_fill;
      for (int i = 0; i < 4; i++) begin
         v_i = 1'b1; ready_i = 1'b0;
         pc_i = 16'(i); inst_i = 32'hA000_0000 + 32'(i);
         @(negedge clk);
         total++;
         if (count_o !== 3'(i + 1)) begin
            bad++; $display("FAIL fill_count%0d: got %0d want %0d", i, count_o, i + 1);
         end
      end
      total++;
      if (stall_o !== 1'b1) begin bad++; $display("FAIL fill_stall: got %b want 1", stall_o); end
      // Fifth beat must be refused
      pc_i = 16'h0004; inst_i = 32'hA000_0004;
      @(negedge clk);
      v_i = 1'b0;
      total++;
      if (count_o !== 3'd4) begin bad++; $display("FAIL fill_5th_count: got %0d want 4", count_o); end
      total++;
      if (pc_o !== 16'h0000) begin bad++; $display("FAIL fill_head: got %h want 0000", pc_o); end
   endtask

   task automatic test_drain;
      v_i = 1'b0; ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++;
         if (v_o !== 1'b1 || pc_o !== 16'(i) || inst_o !== 32'hA000_0000 + 32'(i)) begin
            bad++;
            $display("FAIL drain%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                     i, v_o, pc_o, inst_o, 16'(i), 32'hA000_0000 + 32'(i));
         end
         @(negedge clk);
      end
      total++;
      if (v_o !== 1'b0 || count_o !== 3'd0) begin
         bad++; $display("FAIL drain_empty: got v=%b count=%0d want v=0 count=0", v_o, count_o);
      end
      ready_i = 1'b0;
   endtask

   task automatic test_wrap;
      logic [15:0] exp_pc;
      exp_pc  = 16'h0100;
      ready_i = 1'b1;
      for (int k = 0; k < 21; k++) begin
         v_i    = (k < 20);
         pc_i   = 16'h0100 + 16'(k);
         inst_i = 32'hB000_0000 + 32'(k);
         #1;
         total++;
         if (count_o > 3'd1) begin bad++; $display("FAIL wrap_occ%0d: got %0d want <=1", k, count_o); end
         if (v_o === 1'b1) begin
            total++;
            if (pc_o !== exp_pc) begin
               bad++; $display("FAIL wrap_order%0d: got %h want %h", k, pc_o, exp_pc);
            end
            exp_pc = exp_pc + 16'd1;
         end
         @(negedge clk);
      end
      v_i = 1'b0; ready_i = 1'b0;
      total++;
      if (exp_pc !== 16'h0114) begin
         bad++; $display("FAIL wrap_delivered: got last+1=%h want 0114", exp_pc);
      end
      total++;
      if (v_o !== 1'b0) begin bad++; $display("FAIL wrap_empty: got v=%b want 0", v_o); end
   endtask

   task automatic test_full_concurrent;
      push_n(4, 16'h0500);
      v_i = 1'b1; ready_i = 1'b1; pc_i = 16'h0504; inst_i = 32'hA000_0504;
      #1;
      total++;
      if (stall_o !== 1'b1) begin bad++; $display("FAIL full_pop_stall: got %b want 1", stall_o); end
      @(negedge clk);
      v_i = 1'b0; ready_i = 1'b0;
      total++;
      if (count_o !== 3'd3 || pc_o !== 16'h0501) begin
         bad++; $display("FAIL full_pop_only: got count=%0d pc=%h want count=3 pc=0501", count_o, pc_o);
      end
      ready_i = 1'b1;
      repeat (3) @(negedge clk);
      ready_i = 1'b0;
      total++;
      if (count_o !== 3'd0) begin bad++; $display("FAIL full_pop_drain: got %0d want 0", count_o); end
   endtask

   task automatic test_flush;
      push_n(3, 16'h01F0);
      flush_i = 1'b1; v_i = 1'b1; ready_i = 1'b1; pc_i = 16'h0200; inst_i = 32'hA000_0200;
      @(negedge clk);
      flush_i = 1'b0; v_i = 1'b0;
      total++;
      if (v_o !== 1'b0 || count_o !== 3'd0 || stall_o !== 1'b0) begin
         bad++;
         $display("FAIL flush_state: got v=%b count=%0d stall=%b want v=0 count=0 stall=0",
                  v_o, count_o, stall_o);
      end
      repeat (2) @(negedge clk);
      total++;
      if (v_o !== 1'b0) begin bad++; $display("FAIL flush_no_0200: got v=%b pc=%h want v=0", v_o, pc_o); end
      ready_i = 1'b0;
   endtask

   task automatic test_async_reset;
      push_n(2, 16'h0400);
      total++;
      if (count_o !== 3'd2) begin bad++; $display("FAIL arst_pre: got %0d want 2", count_o); end
      #2 rst = 1'b0;
      #1;
      total++;
      if (v_o !== 1'b0 || count_o !== 3'd0) begin
         bad++; $display("FAIL arst_immediate: got v=%b count=%0d want v=0 count=0", v_o, count_o);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      total++;
      if (v_o !== 1'b0 || count_o !== 3'd0 || stall_o !== 1'b0) begin
         bad++; $display("FAIL arst_after: got v=%b count=%0d stall=%b want 0/0/0", v_o, count_o, stall_o);
      end
      push_n(1, 16'h0410);
      total++;
      if (count_o !== 3'd1 || v_o !== 1'b1 || pc_o !== 16'h0410 || inst_o !== 32'hA000_0410) begin
         bad++;
         $display("FAIL arst_reuse: got count=%0d v=%b pc=%h inst=%h want 1/1/0410/a0000410",
                  count_o, v_o, pc_o, inst_o);
      end
      ready_i = 1'b1;
      @(negedge clk);
      ready_i = 1'b0;
   endtask

`ifdef IQ_BYPASS_EN
   task automatic test_bypass;
      v_i = 1'b1; pc_i = 16'h0300; inst_i = 32'hA000_0300; ready_i = 1'b1;
      #1;
      total++;
      if (v_o !== 1'b1 || pc_o !== 16'h0300) begin
         bad++; $display("FAIL byp_fwd: got v=%b pc=%h want v=1 pc=0300", v_o, pc_o);
      end
      @(negedge clk);
      v_i = 1'b0; ready_i = 1'b0;
      total++;
      if (count_o !== 3'd0 || v_o !== 1'b0) begin
         bad++; $display("FAIL byp_consumed: got count=%0d v=%b want 0/0", count_o, v_o);
      end
   endtask

   task automatic test_bypass_blocked;
      v_i = 1'b1; pc_i = 16'h0300; inst_i = 32'hA000_0300; ready_i = 1'b0;
      #1;
      total++;
      if (v_o !== 1'b1 || pc_o !== 16'h0300) begin
         bad++; $display("FAIL bypb_fwd: got v=%b pc=%h want v=1 pc=0300", v_o, pc_o);
      end
      @(negedge clk);
      v_i = 1'b0;
      total++;
      if (count_o !== 3'd1 || v_o !== 1'b1 || pc_o !== 16'h0300) begin
         bad++; $display("FAIL bypb_stored: got count=%0d v=%b pc=%h want 1/1/0300", count_o, v_o, pc_o);
      end
      ready_i = 1'b1;
      @(negedge clk);
      ready_i = 1'b0;
   endtask
`endif

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_fill();
      test_drain();
      test_wrap();
      test_full_concurrent();
      test_flush();
      test_async_reset();
`ifdef IQ_BYPASS_EN
      test_bypass();
      test_bypass_blocked();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
